desc_wb_slave: RTL and testbench
================================

Name: desc_wb_slave

Overview:
- Wishbone responder that answers the descriptor-fetch and status-writeback traffic issued by the DMA control engine's master port (cyc/stb/we/cab/sel, 64-bit data split across dat and dat64, ack/err/rty).
- Holds descriptors in an on-chip RAM window.
- Serves 4-beat linear cab bursts with back-to-back acks.
- Gives the host (CPU) side a second port for loading and reading descriptors.

Parameters:
- BASE, 32'h0000_1000, byte base address of the window; 8-byte aligned.
- AW, 6, word-address width; depth is 2**AW 64-bit words.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_ni  in  1  reset
- wbs_cyc_i  in  1  cycle
- wbs_stb_i  in  1  strobe
- wbs_we_i  in  1  1 = write
- wbs_cab_i  in  1  burst (linear increment)
- wbs_sel_i  in  4  16-bit lane enables
- wbs_adr_i  in  32  byte address; [2:0] ignored
- wbs_dat_i  in  32  write data [31:0]
- wbs_dat64_i  in  32  write data [63:32]
- wbs_dat_o  out  32  read data [31:0]
- wbs_dat64_o  out  32  read data [63:32]
- wbs_ack_o  out  1  beat done
- wbs_err_o  out  1  address out of window
- wbs_rty_o  out  1  retry, port lost to host
- hst_req  in  1  host access request
- hst_we  in  1  host write
- hst_adr  in  AW  host word address
- hst_dat  in  64  host write data
- hst_gnt  out  1  host access taken this cycle
- hst_rdat  out  64  host read data, valid cycle after gnt

Interface (already decided):
- One clock (wb_clk_i).
- Reset wb_rst_ni is synchronous, active-low.

Behaviour:
- Reset (wb_rst_ni=0 at edge): state=S_IDLE; ack/err/rty=0; dat_o, dat64_o, hst_rdat=0; hst_gnt=0. RAM contents undefined.
- Hit test: hit = adr[31:3] in [BASE>>3, (BASE>>3)+2**AW). Word index widx = adr[AW+2:3] - BASE[AW+2:3].
- Every WB output is ANDed with wbs_cyc_i & wbs_stb_i. The master holds stb high after cyc drops, so no response may escape once cyc falls.
- S_IDLE:
  - hst_req=1: hst_gnt=1 for one cycle; host op executes. Host has priority.
  - If cyc&stb is also high that cycle: go to S_RTY.
  - Else if cyc&stb: latch widx into burst counter bcnt; issue RAM read at widx. Go to S_ERR if !hit, S_WR if we, S_RD otherwise.
- S_RTY: wbs_rty_o=1 for one cycle -> S_IDLE. The start re-evaluates; cyc is still held by the master.
- S_RD:
  - RAM output is 1 cycle behind its address, so the first ack comes 1 cycle after the start cycle.
  - ack=1 with data of word bcnt. On ack: bcnt+1; RAM address = bcnt+1, giving continuous acks.
  - Single (cab=0): one ack -> S_DONE.
  - cab=1: acks continue until cyc falls -> S_IDLE.
  - If bcnt+1 leaves the window: next beat -> S_ERR instead of ack.
- S_WR:
  - ack asserted in the same state each cycle; write of {dat64_i,dat_i} to bcnt on each ack.
  - Lane enables: sel[0]=[15:0], sel[1]=[31:16], sel[2]=[47:32], sel[3]=[63:48].
  - bcnt increments and window exit behave as in S_RD.
- S_ERR: err=1 for one cycle, no RAM write -> S_DONE.
- S_DONE: outputs 0; wait for cyc=0 -> S_IDLE.
- Any state, cyc drops: -> S_IDLE next cycle; no ack/err that cycle.
- Reset mid-burst: abort immediately. Writes already acked remain in RAM.
- Host write and WB read of the same word never overlap, because host access is granted only in S_IDLE.
- bcnt is AW+1 bits so window exit is detected rather than wrapped.

Decomposition:
- Package ssdma_pkg holds: state encodings (S_IDLE..S_DONE, 3 bits), burst length constant BURST_LEN=4, and lane-mask helper constants.
- One sub-module: desc_ram, a 2**AW x 64 synchronous single-port RAM with 4 lane write enables, 1-cycle read. Host and WB share the port through the arbiter in this block.

Test Plan:
- Host writes words 0..3 = 64'h0000_2000_0000_4008, 64'h8080, 0, 0. WB cab read at 0x1000 -> 4 acks on consecutive cycles starting 1 cycle after cyc; data matches; no ack after cyc falls while stb stays 1.
- WB cab write of 4 beats at 0x1040, sel=4'b1111 -> 4 consecutive acks; host read of words 8..11 returns the written data.
- Single write at 0x1008, sel=4'b0001, data 64'hFFFF_FFFF_FFFF_FFFF onto word 64'h0 -> word becomes 64'h0000_0000_0000_FFFF.
- Start cab read at 0x11F8 (last word, AW=6) -> ack with word 63, then err 1 cycle, no further responses until cyc falls.
- Read at 0x0FF8 -> err 1 cycle, no ack.
- hst_req and cyc rise in the same cycle -> hst_gnt=1, rty=1 next cycle; transfer then completes normally with 4 acks.
- Reset asserted after the 2nd ack of a write burst -> all outputs 0 next cycle; beats 0-1 are in RAM, beats 2-3 are not.

Source files
------------

// File: rtl/ssdma_pkg.sv
// ssdma_pkg: shared definitions for the descriptor Wishbone responder.
//   state_e     - responder FSM states (3-bit encoding)
//   BURST_LEN   - beats in a descriptor fetch / status writeback burst
//   LANE_W      - width of one write lane (16 bits)
//   NUM_LANES   - write lanes per 64-bit word
//   DATA_W      - RAM word width
//   LANES_ALL / LANES_NONE - lane-enable masks for full-word and no write
package ssdma_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WR   = 3'd2,
        S_ERR  = 3'd3,
        S_RTY  = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam int BURST_LEN = 4;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;

    localparam logic [NUM_LANES-1:0] LANES_ALL  = 4'b1111;
    localparam logic [NUM_LANES-1:0] LANES_NONE = 4'b0000;

endpackage

// File: rtl/desc_ram.sv
// desc_ram: 2**AW x 64-bit synchronous single-port RAM, one write enable per
// 16-bit lane, registered (1-cycle) read. Read returns the old contents when
// the same address is written in the same cycle.
//   clk_i   - clock
//   we_i    - per-lane write enables (lane n = bits [16n+15:16n])
//   addr_i  - word address
//   wdata_i - write data
//   rdata_o - read data of the address presented on the previous cycle
module desc_ram
    import ssdma_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic                 clk_i,
    input  logic [NUM_LANES-1:0] we_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 2 ** AW;

    // One narrow array per lane keeps the lane enables as plain per-array
    // write enables, which maps directly onto block RAM byte/lane enables.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [LANE_W-1:0] mem_q [DEPTH];
        logic [LANE_W-1:0] rdata_q;

        always_ff @(posedge clk_i) begin
            if (we_i[gi]) begin
                mem_q[addr_i] <= wdata_i[gi*LANE_W +: LANE_W];
            end
            rdata_q <= mem_q[addr_i];
        end

        assign rdata_o[gi*LANE_W +: LANE_W] = rdata_q;
    end

endmodule

// File: rtl/desc_wb_slave.sv
// desc_wb_slave: Wishbone responder for DMA descriptor fetch and status
// writeback, backed by an on-chip descriptor RAM window, plus a host port
// for loading and reading descriptors.
//   wb_clk_i, wb_rst_ni        - clock, synchronous active-low reset
//   wbs_cyc_i/stb_i/we_i/cab_i - Wishbone cycle, strobe, write, linear burst
//   wbs_sel_i                  - 16-bit lane enables for writes
//   wbs_adr_i                  - byte address ([2:0] ignored)
//   wbs_dat_i/dat64_i          - write data [31:0] / [63:32]
//   wbs_dat_o/dat64_o          - read data [31:0] / [63:32]
//   wbs_ack_o/err_o/rty_o      - beat done / outside window / port lost to host
//   hst_req/we/adr/dat         - host access request, write flag, word addr, data
//   hst_gnt                    - host access performed this cycle
//   hst_rdat                   - host read data, valid the cycle after hst_gnt
module desc_wb_slave
    import ssdma_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_1000,
    parameter int          AW   = 6
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic              wbs_cab_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [31:0]       wbs_dat64_i,
    output logic [31:0]       wbs_dat_o,
    output logic [31:0]       wbs_dat64_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic              wbs_rty_o,
    input  logic              hst_req,
    input  logic              hst_we,
    input  logic [AW-1:0]     hst_adr,
    input  logic [63:0]       hst_dat,
    output logic              hst_gnt,
    output logic [63:0]       hst_rdat
);

    // Window bounds in 64-bit word units; one extra bit so the upper bound
    // cannot overflow.
    localparam logic [28:0] BASE_W  = BASE[31:3];
    localparam logic [29:0] LIMIT_W = {1'b0, BASE_W} + (30'd1 << AW);

    state_e              state_q, state_d;
    logic [AW:0]         bcnt_q, bcnt_d;
    logic                hst_rd_q, hst_rd_d;

    logic                wb_act;
    logic                hit;
    logic [AW-1:0]       widx;
    logic [AW:0]         bcnt_inc;

    logic                ack, err, rty, gnt, rd_beat;
    logic [NUM_LANES-1:0] ram_we;
    logic [AW-1:0]       ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;

    logic                unused_adr;
    assign unused_adr = ^wbs_adr_i[2:0];

    // The master may keep stb high after dropping cyc, so every response is
    // qualified by both. Reset also silences the bus combinationally so a
    // burst beat presented during the reset cycle is never acked or written.
    assign wb_act   = wbs_cyc_i & wbs_stb_i & wb_rst_ni;
    assign hit      = (wbs_adr_i[31:3] >= BASE_W) && ({1'b0, wbs_adr_i[31:3]} < LIMIT_W);
    assign widx     = wbs_adr_i[AW+2:3] - BASE[AW+2:3];
    // bcnt carries one extra bit so running off the top of the window is
    // seen as bcnt_inc[AW] instead of wrapping to word 0.
    assign bcnt_inc = bcnt_q + (AW+1)'(1);

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        hst_rd_d  = 1'b0;
        ack       = 1'b0;
        err       = 1'b0;
        rty       = 1'b0;
        gnt       = 1'b0;
        rd_beat   = 1'b0;
        ram_we    = LANES_NONE;
        ram_addr  = bcnt_q[AW-1:0];
        ram_wdata = {wbs_dat64_i, wbs_dat_i};

        case (state_q)
            S_IDLE: begin
                if (hst_req && wb_rst_ni) begin
                    // Host wins the shared RAM port; a simultaneous bus start
                    // is told to retry.
                    gnt       = 1'b1;
                    ram_addr  = hst_adr;
                    ram_wdata = hst_dat;
                    if (hst_we) begin
                        ram_we = LANES_ALL;
                    end else begin
                        hst_rd_d = 1'b1;
                    end
                    if (wb_act) begin
                        state_d = S_RTY;
                    end
                end else if (wb_act) begin
                    bcnt_d   = {1'b0, widx};
                    ram_addr = widx;
                    if (!hit) begin
                        state_d = S_ERR;
                    end else if (wbs_we_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end

            S_RTY: begin
                rty     = wb_act;
                state_d = S_IDLE;
            end

            S_RD: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wb_act) begin
                    ack     = 1'b1;
                    rd_beat = 1'b1;
                    bcnt_d  = bcnt_inc;
                    // Prefetch the next word so a burst acks every cycle.
                    ram_addr = bcnt_inc[AW-1:0];
                    if (!wbs_cab_i) begin
                        state_d = S_DONE;
                    end else if (bcnt_inc[AW]) begin
                        state_d = S_ERR;
                    end
                end
            end

            S_WR: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wb_act) begin
                    ack    = 1'b1;
                    ram_we = wbs_sel_i;
                    bcnt_d = bcnt_inc;
                    if (!wbs_cab_i) begin
                        state_d = S_DONE;
                    end else if (bcnt_inc[AW]) begin
                        state_d = S_ERR;
                    end
                end
            end

            S_ERR: begin
                err     = wb_act;
                state_d = wbs_cyc_i ? S_DONE : S_IDLE;
            end

            S_DONE: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            hst_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            hst_rd_q <= hst_rd_d;
        end
    end

    desc_ram #(
        .AW (AW)
    ) u_ram (
        .clk_i   (wb_clk_i),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign wbs_ack_o   = ack;
    assign wbs_err_o   = err;
    assign wbs_rty_o   = rty;
    assign wbs_dat_o   = rd_beat ? ram_rdata[31:0]  : 32'h0;
    assign wbs_dat64_o = rd_beat ? ram_rdata[63:32] : 32'h0;
    assign hst_gnt     = gnt;
    assign hst_rdat    = hst_rd_q ? ram_rdata : 64'h0;

endmodule

// File: tb/tb_desc_wb_slave.sv
module tb_desc_wb_slave;
    import ssdma_pkg::*;

    localparam int          AW    = 6;
    localparam int          DEPTH = 2 ** AW;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_cab_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat64_i;
    logic [31:0] wbs_dat_o, wbs_dat64_o;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o;
    logic        hst_req, hst_we;
    logic [AW-1:0] hst_adr;
    logic [63:0] hst_dat;
    logic        hst_gnt;
    logic [63:0] hst_rdat;

    always #5 wb_clk_i = ~wb_clk_i;

    desc_wb_slave #(.BASE(BASE), .AW(AW)) dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_ni   (wb_rst_ni),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_cab_i   (wbs_cab_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat64_i (wbs_dat64_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_dat64_o (wbs_dat64_o),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_err_o   (wbs_err_o),
        .wbs_rty_o   (wbs_rty_o),
        .hst_req     (hst_req),
        .hst_we      (hst_we),
        .hst_adr     (hst_adr),
        .hst_dat     (hst_dat),
        .hst_gnt     (hst_gnt),
        .hst_rdat    (hst_rdat)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference memory contents, updated from transaction-level rules.
    logic [63:0] model [DEPTH];
    logic [63:0] beat_wdata [8];
    logic [63:0] beat_rdata [8];
    int n_ack, n_err, n_rty, n_gnt, n_stray, first_resp;
    bit xfer_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] apply_lanes(logic [63:0] old, logic [63:0] nw, logic [3:0] sel);
        logic [63:0] r;
        r = old;
        for (int l = 0; l < 4; l++) begin
            if (sel[l]) r[l*16 +: 16] = nw[l*16 +: 16];
        end
        return r;
    endfunction

    task automatic host_write(input logic [AW-1:0] a, input logic [63:0] d);
        bit got;
        got = 1'b0;
        hst_req = 1'b1; hst_we = 1'b1; hst_adr = a; hst_dat = d;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge wb_clk_i);
            got = hst_gnt;
            @(posedge wb_clk_i); #1;
        end
        hst_req = 1'b0; hst_we = 1'b0;
        chk("host_wr_gnt", 64'(got), 64'd1);
        model[a] = d;
        $display("[%0t] HOST wr word=%0d data=%h", $time, a, d);
    endtask

    task automatic host_read(input logic [AW-1:0] a, output logic [63:0] d);
        bit got;
        got = 1'b0;
        hst_req = 1'b1; hst_we = 1'b0; hst_adr = a;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge wb_clk_i);
            got = hst_gnt;
            @(posedge wb_clk_i); #1;
        end
        hst_req = 1'b0;
        chk("host_rd_gnt", 64'(got), 64'd1);
        @(negedge wb_clk_i);
        d = hst_rdat;
        @(posedge wb_clk_i); #1;
        $display("[%0t] HOST rd word=%0d data=%h", $time, a, d);
    endtask

    task automatic host_check(input logic [AW-1:0] a);
        logic [63:0] d;
        host_read(a, d);
        chk("host_rd_data", d, model[a]);
    endtask

    // Runs one bus cycle: stops after nbeats acks or on err, optionally keeps
    // cyc high for 'hold' more cycles, then drops cyc with stb still high.
    task automatic wb_xfer(input bit we, input bit cab, input logic [31:0] adr,
                           input logic [3:0] sel, input int nbeats, input int hold,
                           input bit with_host);
        int k;
        k = 0;
        xfer_done = 1'b0;
        n_err = 0; n_rty = 0; n_gnt = 0; n_stray = 0; first_resp = -1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_cab_i = cab;
        wbs_sel_i = sel; wbs_adr_i = adr;
        {wbs_dat64_i, wbs_dat_i} = beat_wdata[0];
        if (with_host) begin
            hst_req = 1'b1; hst_we = 1'b0; hst_adr = '0;
        end
        for (int t = 0; t < 40 && !xfer_done; t++) begin
            @(negedge wb_clk_i);
            if (hst_gnt) n_gnt++;
            if (wbs_rty_o) n_rty++;
            if ((wbs_ack_o || wbs_err_o) && first_resp < 0) first_resp = t;
            if (wbs_ack_o && k < 8) begin
                beat_rdata[k] = {wbs_dat64_o, wbs_dat_o};
                k++;
            end
            if (wbs_err_o) begin
                n_err++;
                xfer_done = 1'b1;
            end
            if (k == nbeats) xfer_done = 1'b1;
            @(posedge wb_clk_i); #1;
            hst_req = 1'b0;
            if (k < 8) {wbs_dat64_i, wbs_dat_i} = beat_wdata[k];
        end
        n_ack = k;
        for (int t = 0; t < hold; t++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o || wbs_err_o || wbs_rty_o) n_stray++;
            @(posedge wb_clk_i); #1;
        end
        wbs_cyc_i = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o || wbs_err_o || wbs_rty_o) n_stray++;
            @(posedge wb_clk_i); #1;
        end
        wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cab_i = 1'b0;
        chk("xfer_bounded", 64'(xfer_done), 64'd1);
    endtask

    // Transaction with expectations derived from the window/burst rules.
    task automatic wb_run(input bit we, input bit cab, input logic [31:0] adr,
                          input logic [3:0] sel, input int nbeats, input bit rand_data);
        bit in_win;
        int w, exp_ack, exp_err, hold;
        in_win = (adr >= BASE) && (adr < BASE + 32'(DEPTH * 8));
        w = int'((adr - BASE) >> 3);
        if (!in_win) begin
            exp_ack = 0; exp_err = 1;
        end else if (!cab) begin
            exp_ack = 1; exp_err = 0;
        end else if (w + nbeats <= DEPTH) begin
            exp_ack = nbeats; exp_err = 0;
        end else begin
            exp_ack = DEPTH - w; exp_err = 1;
        end
        hold = (exp_err != 0 || !cab) ? 3 : 0;
        if (rand_data) begin
            for (int i = 0; i < 8; i++) beat_wdata[i] = {$urandom, $urandom};
        end
        wb_xfer(we, cab, adr, sel, nbeats, hold, 1'b0);
        $display("[%0t] WB %s cab=%0d adr=%h sel=%b acks=%0d err=%0d",
                 $time, we ? "wr" : "rd", cab, adr, sel, n_ack, n_err);
        chk("wb_acks", 64'(n_ack), 64'(exp_ack));
        chk("wb_err", 64'(n_err), 64'(exp_err));
        chk("wb_rty", 64'(n_rty), 64'd0);
        chk("wb_first_resp", 64'(first_resp), 64'd1);
        chk("wb_stray", 64'(n_stray), 64'd0);
        for (int i = 0; i < exp_ack; i++) begin
            if (we) begin
                model[w+i] = apply_lanes(model[w+i], beat_wdata[i], sel);
            end else begin
                chk("wb_rd_data", beat_rdata[i], model[w+i]);
            end
        end
    endtask

    initial begin
        logic [63:0] d;
        int k;
        wb_rst_ni = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cab_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0; wbs_dat64_i = '0;
        hst_req = 1'b0; hst_we = 1'b0; hst_adr = '0; hst_dat = '0;
        for (int i = 0; i < 8; i++) begin
            beat_wdata[i] = '0; beat_rdata[i] = '0;
        end

        repeat (3) @(posedge wb_clk_i);
        #1;
        @(negedge wb_clk_i);
        chk("rst_ctl", {60'd0, wbs_ack_o, wbs_err_o, wbs_rty_o, hst_gnt}, 64'd0);
        chk("rst_dat", {wbs_dat64_o, wbs_dat_o}, 64'd0);
        chk("rst_hrdat", hst_rdat, 64'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_ni = 1'b1;

        for (int i = 0; i < DEPTH; i++) host_write(AW'(i), {$urandom, $urandom});

        // Descriptor fetch burst
        host_write(0, 64'h0000_2000_0000_4008);
        host_write(1, 64'h0000_0000_0000_8080);
        host_write(2, 64'h0);
        host_write(3, 64'h0);
        wb_run(1'b0, 1'b1, BASE, 4'hF, BURST_LEN, 1'b1);

        // Status writeback burst, read back by the host
        wb_run(1'b1, 1'b1, BASE + 32'h40, 4'hF, BURST_LEN, 1'b1);
        for (int i = 8; i < 12; i++) host_check(AW'(i));

        // Single write, lane 0 only
        host_write(1, 64'h0);
        beat_wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        wb_run(1'b1, 1'b0, BASE + 32'h8, 4'b0001, 1, 1'b0);
        host_read(1, d);
        chk("lane0_only", d, 64'h0000_0000_0000_FFFF);

        // Burst running off the top of the window, and a miss below it
        wb_run(1'b0, 1'b1, BASE + 32'h1F8, 4'hF, BURST_LEN, 1'b1);
        wb_run(1'b0, 1'b0, BASE - 32'h8, 4'hF, 1, 1'b1);

        // Host and bus start together: host granted, bus retried, then served
        wb_xfer(1'b0, 1'b1, BASE, 4'hF, BURST_LEN, 0, 1'b1);
        $display("[%0t] WB rd with host collision acks=%0d rty=%0d gnt=%0d",
                 $time, n_ack, n_rty, n_gnt);
        chk("coll_gnt", 64'(n_gnt), 64'd1);
        chk("coll_rty", 64'(n_rty), 64'd1);
        chk("coll_acks", 64'(n_ack), 64'(BURST_LEN));
        chk("coll_first_ack", 64'(first_resp), 64'd3);
        chk("coll_stray", 64'(n_stray), 64'd0);
        for (int i = 0; i < BURST_LEN; i++) chk("coll_data", beat_rdata[i], model[i]);

        // Reset after the second ack of a write burst at word 16
        for (int i = 0; i < 8; i++) beat_wdata[i] = {$urandom, $urandom};
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_cab_i = 1'b1;
        wbs_sel_i = 4'hF; wbs_adr_i = BASE + 32'h80;
        {wbs_dat64_i, wbs_dat_i} = beat_wdata[0];
        k = 0;
        for (int t = 0; t < 20 && k < 2; t++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) k++;
            @(posedge wb_clk_i); #1;
            {wbs_dat64_i, wbs_dat_i} = beat_wdata[k];
        end
        chk("rst_burst_acks", 64'(k), 64'd2);
        wb_rst_ni = 1'b0;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        chk("midrst_ctl", {60'd0, wbs_ack_o, wbs_err_o, wbs_rty_o, hst_gnt}, 64'd0);
        chk("midrst_dat", {wbs_dat64_o, wbs_dat_o}, 64'd0);
        chk("midrst_hrdat", hst_rdat, 64'd0);
        @(posedge wb_clk_i); #1;
        wb_rst_ni = 1'b1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cab_i = 1'b0;
        $display("[%0t] WB wr burst aborted by reset after %0d acks", $time, k);
        model[16] = beat_wdata[0];
        model[17] = beat_wdata[1];
        for (int i = 16; i < 20; i++) host_check(AW'(i));

        // Randomized mix of host and bus traffic
        for (int n = 0; n < 40; n++) begin
            int op, wsel, nb;
            bit we, cab;
            logic [31:0] adr;
            op = int'($urandom_range(0, 3));
            if (op == 0) begin
                host_write(AW'($urandom_range(0, DEPTH - 1)), {$urandom, $urandom});
            end else if (op == 1) begin
                host_check(AW'($urandom_range(0, DEPTH - 1)));
            end else begin
                we  = 1'($urandom_range(0, 1));
                cab = 1'($urandom_range(0, 1));
                nb  = cab ? int'($urandom_range(1, BURST_LEN)) : 1;
                wsel = int'($urandom_range(0, 7));
                if (wsel == 0) begin
                    adr = BASE - 32'(8 * $urandom_range(1, 4));
                end else if (wsel == 1) begin
                    adr = BASE + 32'(DEPTH * 8) + 32'(8 * $urandom_range(0, 3));
                end else if (wsel == 2) begin
                    adr = BASE + 32'(8 * $urandom_range(DEPTH - 4, DEPTH - 1));
                end else begin
                    adr = BASE + 32'(8 * $urandom_range(0, DEPTH - 1));
                end
                adr = adr + 32'($urandom_range(0, 7));
                wb_run(we, cab, adr, 4'($urandom_range(0, 15)), nb, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
